// File: rtl/audio_sample_packet_decoder.sv
// Audio sample packet decoder.
//
// Accepts one decoded HDMI Audio Sample Packet (24-bit header plus four 56-bit subpackets).
// It rejects packets with the wrong type, with layout 1, or with an empty present mask.
// Each present subpacket is then unloaded, in ascending order, as one stereo sample on a
// valid/ready stream. The left and right words are parity-checked. The IEC 60958 channel
// status blocks are rebuilt from the C bits, aligned on the header B flags.
//
// Ports:
//   clk_pixel, rst_n        pixel clock, asynchronous active-low reset
//   pkt_valid/pkt_ready     packet handshake; header/sub are sampled on accept
//   header, sub             packet header and subpackets
//   sample_valid/ready      sample stream handshake
//   sample_*                current sample: audio words, V/U bits, parity errors, B flag
//   channel_status_*        last complete channel status block (bit k = frame k)
//   cs_valid, cs_update     block captured since reset / one-cycle publish pulse
//   parity_err_count        saturating count of samples with a parity error
//   pkt_drop                one-cycle pulse after a rejected packet
module audio_sample_packet_decoder #(
  parameter logic [7:0]  PACKET_TYPE           = 8'h02,
  parameter int unsigned CHANNEL_STATUS_LENGTH = 192,
  parameter int unsigned ERR_COUNT_WIDTH       = 16
) (
  input  logic                             clk_pixel,
  input  logic                             rst_n,
  input  logic                             pkt_valid,
  output logic                             pkt_ready,
  input  logic [23:0]                      header,
  input  logic [3:0][55:0]                 sub,
  output logic                             sample_valid,
  input  logic                             sample_ready,
  output logic [23:0]                      sample_left,
  output logic [23:0]                      sample_right,
  output logic [1:0]                       sample_valid_bits,
  output logic [1:0]                       sample_user_bits,
  output logic [1:0]                       sample_parity_err,
  output logic                             sample_block_start,
  output logic [CHANNEL_STATUS_LENGTH-1:0] channel_status_left,
  output logic [CHANNEL_STATUS_LENGTH-1:0] channel_status_right,
  output logic                             cs_valid,
  output logic                             cs_update,
  output logic [ERR_COUNT_WIDTH-1:0]       parity_err_count,
  output logic                             pkt_drop
);

  localparam int unsigned IdxW = $clog2(CHANNEL_STATUS_LENGTH);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(CHANNEL_STATUS_LENGTH - 1);

  typedef enum logic [0:0] {StIdle, StUnload} state_e;

  state_e state_q, state_d;

  logic [3:0][55:0] sub_q;
  logic [3:0]       mask_q, bflag_q;
  logic [1:0]       idx_q, idx_d;
  logic             drop_q;

  logic                       locked_q, locked_d;
  logic [IdxW-1:0]            cs_idx_q, cs_idx_d, wr_idx;
  logic [CHANNEL_STATUS_LENGTH-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
  logic [CHANNEL_STATUS_LENGTH-1:0] cs_l_q, cs_l_d, cs_r_q, cs_r_d;
  logic                       cs_valid_q, cs_valid_d, cs_update_q, cs_update_d;
  logic [ERR_COUNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  logic        accept, pkt_ok, hs;
  logic [55:0] cur;
  logic [1:0]  first_idx, nxt_idx;
  logic        nxt_found;
  logic        par_l, par_r, cur_b;

  logic unused_hdr;
  assign unused_hdr = ^header[19:13];

  assign accept = pkt_valid & pkt_ready;
  assign pkt_ok = (header[7:0] == PACKET_TYPE) & ~header[12] & (|header[11:8]);
  assign hs     = sample_valid & sample_ready;
  assign cur    = sub_q[idx_q];
  assign cur_b  = bflag_q[idx_q];

  // Even parity over word, V, U, C and P of each channel.
  assign par_l = ^{cur[23:0], cur[51:48]};
  assign par_r = ^{cur[47:24], cur[55:52]};

  // Lowest present subpacket of the incoming header (descending scan, lowest wins).
  always_comb begin
    first_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (header[8 + i]) first_idx = 2'(i);
    end
  end

  // Next present subpacket above the current one.
  always_comb begin
    nxt_found = 1'b0;
    nxt_idx   = idx_q;
    for (int i = 3; i >= 0; i--) begin
      if (i > int'(idx_q) && mask_q[i]) begin
        nxt_found = 1'b1;
        nxt_idx   = 2'(i);
      end
    end
  end

  // FSM: state register.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept && pkt_ok) state_d = StUnload;
      StUnload: if (hs && !nxt_found) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    pkt_ready    = (state_q == StIdle);
    sample_valid = (state_q == StUnload);
  end

  always_comb begin
    idx_d = idx_q;
    if (accept && pkt_ok)    idx_d = first_idx;
    else if (hs && nxt_found) idx_d = nxt_idx;
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (hs && (par_l || par_r) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_COUNT_WIDTH'(1);
    end
  end

  // Channel status reassembly. C bits before the first B are discarded; a B flag restarts
  // the block at index 0, so a partial block after a resync is never published.
  always_comb begin
    locked_d    = locked_q;
    cs_idx_d    = cs_idx_q;
    sh_l_d      = sh_l_q;
    sh_r_d      = sh_r_q;
    cs_l_d      = cs_l_q;
    cs_r_d      = cs_r_q;
    cs_valid_d  = cs_valid_q;
    cs_update_d = 1'b0;
    wr_idx      = cs_idx_q;
    if (hs) begin
      if (cur_b) begin
        locked_d = 1'b1;
        wr_idx   = '0;
      end
      if (cur_b || locked_q) begin
        sh_l_d[wr_idx] = cur[50];
        sh_r_d[wr_idx] = cur[54];
        if (wr_idx == LastIdx) begin
          cs_l_d      = sh_l_d;
          cs_r_d      = sh_r_d;
          cs_valid_d  = 1'b1;
          cs_update_d = 1'b1;
          cs_idx_d    = '0;
        end else begin
          cs_idx_d = wr_idx + IdxW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      sub_q       <= '0;
      mask_q      <= '0;
      bflag_q     <= '0;
      idx_q       <= '0;
      drop_q      <= 1'b0;
      locked_q    <= 1'b0;
      cs_idx_q    <= '0;
      sh_l_q      <= '0;
      sh_r_q      <= '0;
      cs_l_q      <= '0;
      cs_r_q      <= '0;
      cs_valid_q  <= 1'b0;
      cs_update_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      if (accept && pkt_ok) begin
        sub_q   <= sub;
        mask_q  <= header[11:8];
        bflag_q <= header[23:20];
      end
      idx_q       <= idx_d;
      drop_q      <= accept & ~pkt_ok;
      locked_q    <= locked_d;
      cs_idx_q    <= cs_idx_d;
      sh_l_q      <= sh_l_d;
      sh_r_q      <= sh_r_d;
      cs_l_q      <= cs_l_d;
      cs_r_q      <= cs_r_d;
      cs_valid_q  <= cs_valid_d;
      cs_update_q <= cs_update_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign sample_left          = cur[23:0];
  assign sample_right         = cur[47:24];
  assign sample_valid_bits    = {cur[52], cur[48]};
  assign sample_user_bits     = {cur[53], cur[49]};
  assign sample_parity_err    = {par_r, par_l};
  assign sample_block_start   = cur_b;
  assign channel_status_left  = cs_l_q;
  assign channel_status_right = cs_r_q;
  assign cs_valid             = cs_valid_q;
  assign cs_update            = cs_update_q;
  assign parity_err_count     = err_cnt_q;
  assign pkt_drop             = drop_q;

endmodule
